if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS pipeline; sits directly upstream of the instruction memory and downstream of the branch/jump resolution logic.
- Owns the program counter and drives the memory's byte address. The memory returns the 32-bit instruction combinationally, from word index PC>>2.
- Registers the instruction and PC+4 into the IF/ID pipeline register, handling stall, redirect and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on bubble or flush (sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_imem_pc  out  32  byte address to instruction memory; equals the PC register.
- IF_imem_instr  in  32  instruction returned combinationally for IF_imem_pc.
- IF_stall  in  1  hazard unit: hold PC and IF/ID contents.
- IF_branch_taken  in  1  EX-stage branch resolved taken.
- IF_branch_target  in  32  branch target address.
- IF_jump  in  1  ID-stage j/jal decoded.
- IF_jump_target  in  32  jump target address.
- IF_halt_req  in  1  WB-stage halt (syscall); one-cycle pulse.
- IFID_instr  out  32  registered instruction.
- IFID_pc_plus4  out  32  registered PC+4 of that instruction.
- IFID_valid  out  1  IFID_instr is a real, non-squashed instruction.
- IF_halted  out  1  stage is in HALTED state.

Behaviour:
- FSM states: BOOT, RUN, HALTED. Reset enters BOOT.
- Reset (async, rst_n=0) sets:
  - PC=RESET_PC, IFID_instr=NOP_INSTR, IFID_pc_plus4=0, IFID_valid=0, IF_halted=0.
- BOOT, one cycle after reset release:
  - PC held; IF/ID loaded with NOP, valid=0; next state RUN.
  - Guarantees the memory contents are settled before the first capture.
- RUN, per rising edge, in priority order:
  1. IF_halt_req=1: PC held; IF/ID <= NOP, valid=0; next state HALTED.
  2. IF_branch_taken=1: PC <= IF_branch_target; IF/ID <= NOP, valid=0 (flush). Overrides an asserted IF_jump, since the branch is the older instruction, and overrides IF_stall.
  3. IF_jump=1: PC <= IF_jump_target; IF/ID <= NOP, valid=0. Overrides IF_stall.
  4. IF_stall=1: PC and all IF/ID outputs hold their values.
  5. Otherwise: PC <= PC+4; IFID_instr <= IF_imem_instr, IFID_pc_plus4 <= PC+4, IFID_valid=1.
- HALTED:
  - PC frozen; IF/ID holds NOP with valid=0; IF_halted=1.
  - All inputs are ignored; only reset exits this state.
- Arithmetic: PC+4 is a 32-bit modulo add, so 32'hFFFF_FFFC wraps to 0. No overflow flag.
- Redirect targets are taken verbatim; this stage does no alignment check.
- Latency: an instruction at address A appears on IFID_instr one clock after PC=A with no stall or redirect.
- Async reset asserted mid-stall or mid-redirect wins immediately; outputs take their reset values without waiting for a clock edge.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, reset to 0 and saturating at 32'hFFFF_FFFF:
  - IF_cnt_fetch: increments on each RUN-case-5 edge.
  - IF_cnt_stall: increments on each RUN-case-4 edge.
  - IF_cnt_flush: increments on each RUN-case-2 or RUN-case-3 edge.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state enum (BOOT, RUN, HALTED);
  - NOP_INSTR and RESET_PC defaults;
  - the INSTR_W=32 and ADDR_W=32 constants.
- One natural sub-module, if_next_pc: purely combinational next-PC priority mux (halt/branch/jump/stall/sequential), instantiated once.
- The PC register, IF/ID register and FSM stay in if_stage.

Test Plan:
- Reset then free run, memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000 -> BOOT cycle with valid=0; then IFID_instr = 0x20080001, 0x20090002, 0x01095020 on consecutive edges; IFID_pc_plus4 = 4, 8, 12.
- IF_stall=1 for 2 cycles while PC=8 -> PC stays 8; IFID holds 0x20090002 / pc_plus4=8; resumes with 0x01095020 after release.
- IF_branch_taken=1 and IF_jump=1 together, branch_target=0x40, jump_target=0x80 -> PC=0x40, IFID_valid=0 for one cycle; next IFID_pc_plus4=0x44.
- IF_jump=1 with IF_stall=1, jump_target=0x10 -> PC=0x10, flush taken, stall ignored.
- IF_halt_req pulse at PC=0x0C -> IF_halted=1 and PC frozen at 0x0C; subsequent branch/jump ignored; rst_n low returns PC=0, IF_halted=0.
- PC forced to 0xFFFF_FFFC via branch_target, then free run -> next PC=0x0000_0000; IFID_pc_plus4=0x0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage
package if_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
  typedef enum logic [2:0] {ACT_IDLE, ACT_HALT, ACT_REDIR, ACT_STALL, ACT_SEQ} act_e;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: combinational next-PC priority mux (halt > branch > jump > stall > sequential)
module if_next_pc
  import if_stage_pkg::*;
(
  input  state_e            state_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              halt_req_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              stall_i,
  output act_e              act_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] pc_next_o
);
  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    act_o = state_i != RUN ? ACT_IDLE :
            halt_req_i ? ACT_HALT :
            (branch_taken_i || jump_i) ? ACT_REDIR :
            stall_i ? ACT_STALL : ACT_SEQ;
    pc_next_o = act_o == ACT_REDIR ? (branch_taken_i ? branch_target_i : jump_target_i) :
                act_o == ACT_SEQ ? pc_plus4_o : pc_i;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage owning PC, IF/ID register and BOOT/RUN/HALTED FSM; IF_PERF_CNT_EN adds counters
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  IF_imem_pc,
  input  logic [INSTR_W-1:0] IF_imem_instr,
  input  logic               IF_stall,
  input  logic               IF_branch_taken,
  input  logic [ADDR_W-1:0]  IF_branch_target,
  input  logic               IF_jump,
  input  logic [ADDR_W-1:0]  IF_jump_target,
  input  logic               IF_halt_req,
  output logic [INSTR_W-1:0] IFID_instr,
  output logic [ADDR_W-1:0]  IFID_pc_plus4,
  output logic               IFID_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        IF_cnt_fetch,
  output logic [31:0]        IF_cnt_stall,
  output logic [31:0]        IF_cnt_flush,
`endif
  output logic               IF_halted
);
  state_e state_q, state_d;
  act_e act;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  if_next_pc u_next_pc (
    .state_i(state_q),
    .pc_i(pc_q),
    .halt_req_i(IF_halt_req),
    .branch_taken_i(IF_branch_taken),
    .branch_target_i(IF_branch_target),
    .jump_i(IF_jump),
    .jump_target_i(IF_jump_target),
    .stall_i(IF_stall),
    .act_o(act),
    .pc_plus4_o(pc_plus4),
    .pc_next_o(pc_d)
  );
  always_comb begin
    state_d = state_q == BOOT ? RUN : act == ACT_HALT ? HALTED : state_q;
    instr_d = act == ACT_SEQ ? IF_imem_instr : act == ACT_STALL ? instr_q : NOP_INSTR;
    valid_d = act == ACT_SEQ ? 1'b1 : act == ACT_STALL ? valid_q : 1'b0;
    pc4_d = act == ACT_SEQ ? pc_plus4 : pc4_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_q, stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (act == ACT_SEQ && fetch_q != '1) fetch_q <= fetch_q + 32'd1;
      if (act == ACT_STALL && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (act == ACT_REDIR && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end
  assign IF_cnt_fetch = fetch_q;
  assign IF_cnt_stall = stall_q;
  assign IF_cnt_flush = flush_q;
`endif
  assign IF_imem_pc = pc_q;
  assign IFID_instr = instr_q;
  assign IFID_pc_plus4 = pc4_q;
  assign IFID_valid = valid_q;
  assign IF_halted = state_q == HALTED;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc, instr, bt, jt, id_instr, id_pc4;
  logic stall = 1'b0, br = 1'b0, jmp = 1'b0, halt = 1'b0, valid, halted;
  logic [31:0] mem [64];
  int pass = 0, total = 0;

  always #5 clk = ~clk;
  assign instr = pc[31:8] == 24'd0 ? mem[pc[7:2]] : 32'hDEAD_BEEF;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .IF_imem_pc(pc), .IF_imem_instr(instr),
    .IF_stall(stall), .IF_branch_taken(br), .IF_branch_target(bt),
    .IF_jump(jmp), .IF_jump_target(jt), .IF_halt_req(halt),
    .IFID_instr(id_instr), .IFID_pc_plus4(id_pc4), .IFID_valid(valid),
    .IF_halted(halted)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; br = 0; jmp = 0; halt = 0; bt = 0; jt = 0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else pass++; total++;
    if ({id_instr, id_pc4, valid, halted} !== 66'h0) $display("FAIL reset_ifid got %h/%h/%b/%b want 0", id_instr, id_pc4, valid, halted); else pass++; total++;
    edge1();
    if (valid !== 1'b0 || pc !== 32'h0) $display("FAIL boot got valid=%b pc=%h want 0/0", valid, pc); else pass++; total++;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h2008_0001; exp_i[1] = 32'h2009_0002; exp_i[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) begin
      edge1();
      if (id_instr !== exp_i[i] || id_pc4 !== 32'(4*(i+1)) || valid !== 1'b1)
        $display("FAIL run%0d got %h/%h/%b want %h/%h/1", i, id_instr, id_pc4, valid, exp_i[i], 32'(4*(i+1)));
      else pass++;
      total++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    edge1(); edge1(); edge1();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge1();
      if (pc !== 32'h8 || id_instr !== 32'h2009_0002 || id_pc4 !== 32'h8 || valid !== 1'b1)
        $display("FAIL stall%0d got pc=%h %h/%h/%b want 8 20090002/8/1", i, pc, id_instr, id_pc4, valid);
      else pass++;
      total++;
    end
    stall = 1'b0;
    edge1();
    if (id_instr !== 32'h0109_5020 || id_pc4 !== 32'hC || pc !== 32'hC)
      $display("FAIL stall_release got %h/%h pc=%h want 01095020/c pc=c", id_instr, id_pc4, pc);
    else pass++;
    total++;
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    edge1();
    #2 rst_n = 1'b0;
    #1;
    if (pc !== 32'h0 || valid !== 1'b0 || id_instr !== 32'h0 || id_pc4 !== 32'h0)
      $display("FAIL async_reset got pc=%h %h/%h/%b want 0", pc, id_instr, id_pc4, valid);
    else pass++;
    total++;
    do_reset();
    edge1(); edge1(); edge1(); edge1();
  endtask

  task automatic test_branch_jump();
    br = 1'b1; bt = 32'h40; jmp = 1'b1; jt = 32'h80;
    edge1();
    if (pc !== 32'h40 || valid !== 1'b0) $display("FAIL br_over_jmp got pc=%h valid=%b want 40/0", pc, valid); else pass++; total++;
    br = 1'b0; jmp = 1'b0;
    edge1();
    if (id_pc4 !== 32'h44 || valid !== 1'b1 || id_instr !== 32'hA000_0010)
      $display("FAIL br_next got %h/%h/%b want a0000010/44/1", id_instr, id_pc4, valid);
    else pass++;
    total++;
  endtask

  task automatic test_jump_stall();
    jmp = 1'b1; jt = 32'h10; stall = 1'b1;
    edge1();
    if (pc !== 32'h10 || valid !== 1'b0) $display("FAIL jmp_stall got pc=%h valid=%b want 10/0", pc, valid); else pass++; total++;
    jmp = 1'b0; stall = 1'b0;
    edge1();
    if (id_instr !== 32'hA000_0004 || id_pc4 !== 32'h14) $display("FAIL jmp_next got %h/%h want a0000004/14", id_instr, id_pc4); else pass++; total++;
  endtask

  task automatic test_halt();
    jmp = 1'b1; jt = 32'hC;
    edge1();
    jmp = 1'b0; halt = 1'b1;
    edge1();
    halt = 1'b0;
    if (halted !== 1'b1 || pc !== 32'hC || valid !== 1'b0) $display("FAIL halt got h=%b pc=%h v=%b want 1/c/0", halted, pc, valid); else pass++; total++;
    br = 1'b1; bt = 32'h40; jmp = 1'b1; jt = 32'h80;
    edge1(); edge1();
    if (halted !== 1'b1 || pc !== 32'hC || valid !== 1'b0 || id_instr !== 32'h0)
      $display("FAIL halt_hold got h=%b pc=%h v=%b i=%h want 1/c/0/0", halted, pc, valid, id_instr);
    else pass++;
    total++;
    rst_n = 1'b0;
    #1;
    if (pc !== 32'h0 || halted !== 1'b0) $display("FAIL halt_reset got pc=%h h=%b want 0/0", pc, halted); else pass++; total++;
    do_reset();
  endtask

  task automatic test_wrap();
    edge1();
    br = 1'b1; bt = 32'hFFFF_FFFC;
    edge1();
    br = 1'b0;
    if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h want fffffffc", pc); else pass++; total++;
    edge1();
    if (pc !== 32'h0 || id_pc4 !== 32'h0 || valid !== 1'b1 || id_instr !== 32'hDEAD_BEEF)
      $display("FAIL wrap got pc=%h %h/%h/%b want 0 deadbeef/0/1", pc, id_instr, id_pc4, valid);
    else pass++;
    total++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002; mem[2] = 32'h0109_5020; mem[3] = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_async_reset();
    test_branch_jump();
    test_jump_stall();
    test_halt();
    test_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
